// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: op and FSM state encodings, plus a small op classifier.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ADD and SUB are the only ops that produce a meaningful carry and overflow
    function automatic logic is_arith(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle between the operand stage and the bit-serial ALU sequencer.
interface alu_serial_if #(parameter int N = 8);

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   op;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, op,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, result, cout, ovf
    );

endinterface

// File: rtl/alu1bit.sv
// One-bit ALU slice: NOR, XOR, or a full-adder whose B input is inverted by op[0] for SUB.
module alu1bit
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       s,
    output logic       cout
);

    logic b_eff;
    logic sum;
    logic carry;

    // slice logic; the carry leaves as 0 for the logical ops
    always_comb begin
        b_eff = b ^ op[0];
        sum   = a ^ b_eff ^ cin;
        carry = (a & b_eff) | (cin & (a ^ b_eff));
        s     = 1'b0;
        cout  = 1'b0;
        case (op)
            OP_NOR: begin
                s    = ~(a | b);
                cout = 1'b0;
            end
            OP_XOR: begin
                s    = a ^ b;
                cout = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                s    = sum;
                cout = carry;
            end
            default: begin
                s    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial N-bit ALU sequencer: feeds one alu1bit slice LSB first and assembles the result.
module alu_serial
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_serial_if.slave  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q,  state_d;
    logic [N-1:0]  a_sh_q,   a_sh_d;
    logic [N-1:0]  b_sh_q,   b_sh_d;
    logic [1:0]    op_q,     op_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          carry_q,  carry_d;
    logic [N-1:0]  result_q, result_d;
    logic          cout_q,   cout_d;
    logic          ovf_q,    ovf_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic          alu_s;
    logic          alu_cout;

    alu1bit u_alu1bit (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .op   (op_q),
        .s    (alu_s),
        .cout (alu_cout)
    );

    // next-state and datapath update for the IDLE/RUN/DONE sequencer
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    op_d     = bus.op;
                    cnt_d    = {CW{1'b0}};
                    // SUB is A + ~B + 1: the +1 enters as the initial carry
                    carry_d  = (bus.op == OP_SUB);
                    result_d = {N{1'b0}};
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                result_d = {alu_s, result_q[N-1:1]};
                carry_d  = alu_cout;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = is_arith(op_q) ? alu_cout : 1'b0;
                    // carry_q here is the carry into the MSB
                    ovf_d   = is_arith(op_q) ? (carry_q ^ alu_cout) : 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // sequencer state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= {N{1'b0}};
            b_sh_q   <= {N{1'b0}};
            op_q     <= 2'b00;
            cnt_q    <= {CW{1'b0}};
            carry_q  <= 1'b0;
            result_q <= {N{1'b0}};
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Bit-serial N-bit ALU sequencer that drives a single alu1bit instance, one bit per clock, LSB first.
- Latches two N-bit operands and an op, shifts them through the 1-bit ALU, registers the carry between bits, and assembles the N-bit result.
- Sits between the register-file/operand stage (upstream) and alu1bit (downstream), and consumes alu1bit's s/cout each cycle.
- Trades N cycles of latency for one 1-bit slice instead of N slices.

Parameters:
- N, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- a  input  N  operand A; captured on an accepted start
- b  input  N  operand B; captured on an accepted start
- op  input  2  operation; captured on an accepted start (encoding in alu_pkg)
- busy  output  1  high while the operation is in progress (RUN)
- done  output  1  single-cycle pulse; result/cout/ovf are valid from this cycle
- result  output  N  assembled result; held until the next accepted start
- cout  output  1  carry out of the MSB (ADD/SUB only, else 0)
- ovf  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0, carry flop=0.
- Op encoding:
  - 00 NOR
  - 01 XOR
  - 10 ADD
  - 11 SUB
- SUB is computed as A + ~B + 1:
  - alu1bit performs the B inversion from op[0].
  - The sequencer seeds the carry flop with 1 for SUB and 0 otherwise.
- States: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at a rising edge, capture a, b and op into shift registers.
  - Set the counter to 0, seed the carry, clear result, go to RUN.
  - start=0 keeps IDLE.
- RUN:
  - alu1bit inputs are a_sh[0], b_sh[0], carry flop, op_q.
  - At each edge: shift a_sh/b_sh right by 1, shift s into result MSB (result shifts right), carry flop <= alu cout, counter++.
  - On the edge processing bit N-1:
    - Latch cout = alu cout (ADD/SUB), else 0.
    - Latch ovf = carry-in to MSB XOR alu cout (ADD/SUB), else 0.
    - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE. busy=0.
  - A start in DONE is ignored; start is accepted only in IDLE.
- Latency:
  - start accepted at edge k; bits processed at edges k+1..k+N; done high in the cycle after edge k+N.
  - The next start is accepted at edge k+N+1 at the earliest.
- busy=1 exactly in RUN, for N cycles.
- start while busy or in DONE: ignored. Operand, op and result registers are unaffected.
- Changes on a/b/op after acceptance have no effect.
- Reset mid-RUN: all state returns to reset values immediately, without waiting for clk. The partial result is discarded and done is not pulsed.
- Timing: the alu1bit path includes modelled gate delays (up to ~30 time units). The clock period must exceed the settle time of the slowest path; the bench uses a period of 100 time units.

Decomposition:
- Package alu_pkg:
  - op_t enum (OP_NOR, OP_XOR, OP_ADD, OP_SUB)
  - state_t enum (S_IDLE, S_RUN, S_DONE)
  - helper is_arith(op) = op[1]
- One sub-module: alu1bit, instantiated once and unmodified.
- Counter width: $clog2(N).

Test Plan:
- Reset, then ADD a=0x3C b=0x0F -> result=0x4B, cout=0, ovf=0. busy high 8 cycles, done pulses once, 8 cycles after the start edge.
- ADD a=0xFF b=0x01 -> result=0x00, cout=1, ovf=0. ADD a=0x7F b=0x01 -> result=0x80, cout=0, ovf=1.
- SUB a=0x05 b=0x07 -> result=0xFE, cout=0, ovf=0. SUB a=0x80 b=0x01 -> result=0x7F, cout=1, ovf=1.
- NOR a=0xA5 b=0x0F -> result=0x50, cout=0, ovf=0. XOR same operands -> result=0xAA.
- start re-asserted with different a/b during RUN and during DONE -> ignored; the first operation's result is unchanged. A start the cycle after done is accepted.
- rst asserted mid-RUN (after bit 3), between clock edges -> busy, done and result go to 0 immediately. After release, ADD 0x01+0x01 -> 0x02 correctly.
